// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_pkg
// Purpose  : Shared widths, opcode constants and fetch-action encoding for
//            the 14-bit MCU core.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_pkg;

   localparam int PC_W    = 11;
   localparam int INSTR_W = 14;

   localparam logic [2:0]  OP_GOTO_HI   = 3'b101;
   localparam logic [2:0]  OP_CALL_HI   = 3'b100;
   localparam logic [3:0]  OP_RETLW_HI  = 4'b1101;
   localparam logic [13:0] INSTR_RETURN = 14'h0008;
   localparam logic [13:0] INSTR_RETFIE = 14'h0009;
   localparam logic [13:0] INSTR_NOP    = 14'h0000;

   // What the fetch unit does with the PC this cycle
   typedef enum logic [2:0] {
      ACT_SEQ  = 3'd0,
      ACT_JUMP = 3'd1,
      ACT_CALL = 3'd2,
      ACT_RET  = 3'd3,
      ACT_SKIP = 3'd4
   } fetch_act_e;

endpackage
`default_nettype wire

// File: rtl/hw_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : hw_return_stack
// Purpose  : Circular hardware LIFO of return addresses with a saturating
//            occupancy counter. Push at full overwrites the oldest entry,
//            pop at empty reads the entry at the wrapped pointer.
//            Optional sticky overflow/underflow flags: PC_FETCH_STACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hw_return_stack #(
   parameter int DEPTH = 8,
   parameter int W     = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             push_data_i,
   output logic [W-1:0]             tos_o,
   output logic [$clog2(DEPTH):0]   depth_o
`ifdef PC_FETCH_STACK_ERR_EN
   ,
   output logic                     ovf_o,
   output logic                     unf_o
`endif
);

   localparam int               PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d;
   logic [PTR_W:0]   depth_q, depth_d;
   logic [PTR_W-1:0] top_ptr;
   logic             full, empty;

   assign top_ptr = sp_q - PTR_W'(1);
   assign tos_o   = mem_q[top_ptr];
   assign depth_o = depth_q;
   assign full    = (depth_q == C_FULL);
   assign empty   = (depth_q == '0);

   // Entry storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[sp_q] <= push_data_i;
      end
   end

   // Next pointer and saturating depth; pointer always wraps freely
   always_comb begin
      sp_d    = sp_q;
      depth_d = depth_q;
      if (push_i) begin
         sp_d = sp_q + PTR_W'(1);
         if (!full) depth_d = depth_q + (PTR_W+1)'(1);
      end else if (pop_i) begin
         sp_d = top_ptr;
         if (!empty) depth_d = depth_q - (PTR_W+1)'(1);
      end
   end

   // Pointer and depth registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q    <= '0;
         depth_q <= '0;
      end else begin
         sp_q    <= sp_d;
         depth_q <= depth_d;
      end
   end

`ifdef PC_FETCH_STACK_ERR_EN
   logic ovf_q, unf_q;
   assign ovf_o = ovf_q;
   assign unf_o = unf_q;

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push_i && full)  ovf_q <= 1'b1;
         if (pop_i  && empty) unf_q <= 1'b1;
      end
   end

   // Flag each wrap event in simulation
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push_i && full))  else $warning("return stack overflow");
         assert (!(pop_i  && empty)) else $warning("return stack underflow");
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : Program counter and two-stage fetch sequencer. Resolves GOTO,
//            CALL, RETURN/RETFIE/RETLW via an internal return stack, accepts
//            skip / computed-jump / stall from execute, and flushes the
//            wrong-path fetch (one bubble per taken branch).
//            Optional stack error flags: PC_FETCH_STACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
   import mcu_pkg::*;
#(
   parameter int               PC_W        = mcu_pkg::PC_W,
   parameter int               INSTR_W     = mcu_pkg::INSTR_W,
   parameter int               STACK_DEPTH = 8,
   parameter logic [PC_W-1:0]  RESET_VEC   = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   output logic [PC_W-1:0]                rom_addr_o,
   input  logic [INSTR_W-1:0]             rom_data_i,
   output logic [INSTR_W-1:0]             ir_o,
   output logic                           ir_valid_o,
   output logic [PC_W-1:0]                ir_pc_o,
   input  logic                           stall_i,
   input  logic                           skip_i,
   input  logic                           pc_load_i,
   input  logic [PC_W-1:0]                pc_load_addr_i,
   output logic [$clog2(STACK_DEPTH):0]   stack_depth_o
`ifdef PC_FETCH_STACK_ERR_EN
   ,
   output logic                           stack_ovf_o,
   output logic                           stack_unf_o
`endif
);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               ir_valid_q, ir_valid_d;
   logic [PC_W-1:0]    ir_pc_q, ir_pc_d;

   fetch_act_e         act;
   logic [PC_W-1:0]    tos;
   logic               exec;
   logic               is_ret;

   assign rom_addr_o = pc_q;
   assign ir_o       = ir_q;
   assign ir_valid_o = ir_valid_q;
   assign ir_pc_o    = ir_pc_q;

   // Only a real, unstalled instruction may redirect fetch
   assign exec   = ir_valid_q && !stall_i;
   assign is_ret = (ir_q == INSTR_RETURN) || (ir_q == INSTR_RETFIE) ||
                   (ir_q[INSTR_W-1 -: 4] == OP_RETLW_HI);

   // Decode the action: opcode control flow beats pc_load, which beats skip
   always_comb begin
      act = ACT_SEQ;
      if (exec) begin
         if      (ir_q[INSTR_W-1 -: 3] == OP_GOTO_HI) act = ACT_JUMP;
         else if (ir_q[INSTR_W-1 -: 3] == OP_CALL_HI) act = ACT_CALL;
         else if (is_ret)                             act = ACT_RET;
         else if (pc_load_i)                          act = ACT_JUMP;
         else if (skip_i)                             act = ACT_SKIP;
      end
   end

   // Next PC / IR; any non-sequential action squashes the fetch in flight
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      ir_pc_d    = ir_pc_q;
      if (!stall_i) begin
         ir_pc_d    = pc_q;
         ir_d       = rom_data_i;
         ir_valid_d = 1'b1;
         unique case (act)
            ACT_JUMP: pc_d = (exec && !is_ret && ir_q[INSTR_W-1 -: 3] == OP_GOTO_HI)
                             ? ir_q[PC_W-1:0] : pc_load_addr_i;
            ACT_CALL: pc_d = ir_q[PC_W-1:0];
            ACT_RET:  pc_d = tos;
            default:  pc_d = pc_q + PC_W'(1);
         endcase
         if (act != ACT_SEQ) begin
            ir_d       = INSTR_NOP;
            ir_valid_d = 1'b0;
         end
      end
   end

   // Fetch pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VEC;
         ir_q       <= INSTR_NOP;
         ir_valid_q <= 1'b0;
         ir_pc_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         ir_pc_q    <= ir_pc_d;
      end
   end

   hw_return_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_stack (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (act == ACT_CALL),
      .pop_i       (act == ACT_RET),
      .push_data_i (pc_q),
      .tos_o       (tos),
      .depth_o     (stack_depth_o)
`ifdef PC_FETCH_STACK_ERR_EN
      ,
      .ovf_o       (stack_ovf_o),
      .unf_o       (stack_unf_o)
`endif
   );

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed self-checking bench for pc_fetch_ctrl with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] rom_addr;
   logic [13:0] rom_data;
   logic [13:0] ir;
   logic        ir_valid;
   logic [10:0] ir_pc;
   logic        stall = 1'b0, skip = 1'b0, pc_load = 1'b0;
   logic [10:0] pc_load_addr = '0;
   logic [3:0]  depth;
`ifdef PC_FETCH_STACK_ERR_EN
   logic        ovf, unf;
`endif

   logic [13:0] rom [2048];
   int          tests = 0;
   int          fails = 0;

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr_o     (rom_addr),
      .rom_data_i     (rom_data),
      .ir_o           (ir),
      .ir_valid_o     (ir_valid),
      .ir_pc_o        (ir_pc),
      .stall_i        (stall),
      .skip_i         (skip),
      .pc_load_i      (pc_load),
      .pc_load_addr_i (pc_load_addr),
      .stack_depth_o  (depth)
`ifdef PC_FETCH_STACK_ERR_EN
      ,
      .stack_ovf_o    (ovf),
      .stack_unf_o    (unf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill_rom();
      for (int a = 0; a < 2048; a++) rom[a] = 14'h0700 | 14'(a & 8'hFF);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall = 1'b0; skip = 1'b0; pc_load = 1'b0;
      tick(2);
      check("rst_addr",  32'(rom_addr), 32'h0);
      check("rst_ir",    32'(ir),       32'h0);
      check("rst_valid", 32'(ir_valid), 32'h0);
      check("rst_irpc",  32'(ir_pc),    32'h0);
      check("rst_depth", 32'(depth),    32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      // ---------------- main program image ----------------
      fill_rom();
      rom[11'h000] = 14'h01A5;
      rom[11'h001] = 14'h0103;
      rom[11'h002] = 14'h3001;
      rom[11'h005] = 14'h2030;   // CALL 0x030
      rom[11'h012] = 14'h2804;   // GOTO 0x004
      rom[11'h030] = 14'h3400;   // RETLW 0

      do_reset();
      check("rel_valid", 32'(ir_valid), 32'h0);

      // reset release / sequential fetch
      tick(); check("c1_ir", 32'(ir), 32'h01A5); check("c1_valid", 32'(ir_valid), 1);
              check("c1_irpc", 32'(ir_pc), 32'h0); check("c1_addr", 32'(rom_addr), 32'h1);
      tick(); check("c2_ir", 32'(ir), 32'h0103); check("c2_irpc", 32'(ir_pc), 32'h1);
              check("c2_addr", 32'(rom_addr), 32'h2);
      tick(); check("c3_ir", 32'(ir), 32'h3001); check("c3_addr", 32'(rom_addr), 32'h3);

      // CALL at 0x05 -> RETLW at 0x30 -> back to 0x06
      tick(3); check("call_ir", 32'(ir), 32'h2030); check("call_irpc", 32'(ir_pc), 32'h5);
      tick(); check("call_bub", 32'(ir_valid), 0); check("call_nop", 32'(ir), 0);
              check("call_addr", 32'(rom_addr), 32'h30); check("call_depth", 32'(depth), 1);
      tick(); check("retlw_ir", 32'(ir), 32'h3400); check("retlw_valid", 32'(ir_valid), 1);
              check("retlw_irpc", 32'(ir_pc), 32'h30);
      tick(); check("ret_bub", 32'(ir_valid), 0); check("ret_addr", 32'(rom_addr), 32'h6);
              check("ret_depth", 32'(depth), 0);
      tick(); check("ret_irpc", 32'(ir_pc), 32'h6); check("ret_valid", 32'(ir_valid), 1);

      // skip on 0x0B suppresses 0x0C
      tick(5); check("skip_irpc", 32'(ir_pc), 32'hB);
      skip = 1'b1;
      tick(); check("skip_bub", 32'(ir_valid), 0); check("skip_addr", 32'(rom_addr), 32'hD);
      skip = 1'b0;
      tick(); check("skip_next", 32'(ir_pc), 32'hD); check("skip_nvalid", 32'(ir_valid), 1);

      // GOTO at 0x12 -> 0x004
      tick(5); check("goto_ir", 32'(ir), 32'h2804); check("goto_irpc", 32'(ir_pc), 32'h12);
      tick(); check("goto_bub", 32'(ir_valid), 0); check("goto_addr", 32'(rom_addr), 32'h4);
      tick(); check("goto_irpc4", 32'(ir_pc), 32'h4); check("goto_depth", 32'(depth), 0);

      // stall with pending skip and pc_load: everything frozen
      stall = 1'b1; skip = 1'b1; pc_load = 1'b1; pc_load_addr = 11'h7FF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr",  32'(rom_addr), 32'h5);
         check("stall_ir",    32'(ir),       32'h0704);
         check("stall_irpc",  32'(ir_pc),    32'h4);
         check("stall_valid", 32'(ir_valid), 1);
      end
      skip = 1'b0; pc_load = 1'b0; stall = 1'b0;
      tick(); check("resume_ir", 32'(ir), 32'h2030); check("resume_irpc", 32'(ir_pc), 32'h5);

      // CALL beats pc_load; pc_load ignored during bubble; RETLW beats pc_load
      pc_load = 1'b1; pc_load_addr = 11'h7FE;
      tick(); check("pri_call_addr", 32'(rom_addr), 32'h30); check("pri_call_depth", 32'(depth), 1);
      tick(); check("bub_ignore_addr", 32'(rom_addr), 32'h31); check("bub_ignore_ir", 32'(ir), 32'h3400);
      tick(); check("pri_ret_addr", 32'(rom_addr), 32'h6); check("pri_ret_depth", 32'(depth), 0);
      pc_load = 1'b0;
      tick(); check("pri_ret_irpc", 32'(ir_pc), 32'h6);

      // pc_load beats skip; PC wrap 0x7FF -> 0x000
      pc_load = 1'b1; skip = 1'b1;
      tick(); check("load_addr", 32'(rom_addr), 32'h7FE); check("load_bub", 32'(ir_valid), 0);
      pc_load = 1'b0; skip = 1'b0;
      tick(); check("load_irpc", 32'(ir_pc), 32'h7FE); check("load_valid", 32'(ir_valid), 1);
      tick(); check("wrap_irpc", 32'(ir_pc), 32'h7FF); check("wrap_addr", 32'(rom_addr), 32'h0);

      // ---------------- nested-call image ----------------
      fill_rom();
      for (int k = 1; k <= 9; k++) rom[(k-1)*64] = 14'h2000 | 14'(k*64);
      rom[11'h240] = 14'h0008;
      for (int k = 1; k <= 8; k++) rom[k*64+1] = 14'h0008;

      do_reset();
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("ncall_ir", 32'(ir), 32'(14'h2000 | 14'(k*64)));
         check("ncall_valid", 32'(ir_valid), 1);
`ifdef PC_FETCH_STACK_ERR_EN
         check("ovf_clear", 32'(ovf), 0);
`endif
         tick();
         check("ncall_depth", 32'(depth), 32'((k > 8) ? 8 : k));
         check("ncall_addr", 32'(rom_addr), 32'(k*64));
      end
`ifdef PC_FETCH_STACK_ERR_EN
      check("ovf_set", 32'(ovf), 1);
`endif
      for (int j = 1; j <= 9; j++) begin
         tick();
         check("nret_ir", 32'(ir), 32'h0008);
`ifdef PC_FETCH_STACK_ERR_EN
         check("unf_clear", 32'(unf), 0);
`endif
         tick();
         check("nret_depth", 32'(depth), 32'((j > 8) ? 0 : 8 - j));
         check("nret_addr", 32'(rom_addr), 32'((j > 8) ? 11'h201 : (9 - j) * 64 + 1));
         check("nret_bub", 32'(ir_valid), 0);
      end
`ifdef PC_FETCH_STACK_ERR_EN
      check("unf_set", 32'(unf), 1);
`endif
      tick(); check("wrap_ret_irpc", 32'(ir_pc), 32'h201); check("wrap_ret_valid", 32'(ir_valid), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program counter and instruction-fetch sequencer for the 14-bit MCU core, driving the combinational program ROM address and latching its output into the instruction register (IR).
- Two-stage fetch/execute pipeline.
- Resolves GOTO, CALL, RETURN, RETFIE and RETLW itself through an internal 8-level hardware return stack.
- Accepts skip, computed-PC-load and stall requests from the execute stage.
- Flushes the wrong-path fetch, giving PIC-style two-cycle branches.

Parameters:
- PC_W, 11: program address width; ROM depth is 2^PC_W words.
- INSTR_W, 14: instruction width.
- STACK_DEPTH, 8: return-stack entries; must be a power of two.
- RESET_VEC, 11'h000: PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rom_addr_o  output  PC_W  address to program ROM; equals the PC register.
- rom_data_i  input  INSTR_W  combinational ROM data for rom_addr_o.
- ir_o  output  INSTR_W  instruction presented to execute.
- ir_valid_o  output  1  ir_o is a real instruction; 0 means bubble/NOP.
- ir_pc_o  output  PC_W  address ir_o was fetched from.
- stall_i  input  1  execute busy; freeze PC, IR, stack.
- skip_i  input  1  execute resolved skip (DECFSZ/BTFSS...) for the current IR.
- pc_load_i  input  1  computed jump (PCL write) by the current IR.
- pc_load_addr_i  input  PC_W  target for pc_load_i.
- stack_depth_o  output  $clog2(STACK_DEPTH)+1  saturating occupancy count, debug.

Behaviour:
- Reset values, asynchronous on rst_n=0:
  - pc = RESET_VEC, ir_o = 0 (NOP), ir_valid_o = 0, ir_pc_o = 0.
  - stack pointer = 0, stack_depth_o = 0.
  - Stack contents are not reset.
- First cycle after release: ROM fetches RESET_VEC; ir_valid_o=1 from the second cycle.
- Normal cycle (stall_i=0):
  - IR <= rom_data_i; ir_pc_o <= pc; pc <= pc+1; ir_valid_o <= 1.
  - pc wraps modulo 2^PC_W (0x7FF -> 0x000).
- stall_i=1: pc, IR, ir_valid_o and stack hold. skip_i and pc_load_i are ignored.
- Execute actions are taken only when ir_valid_o=1 and stall_i=0. Decode is on ir_o.
  - GOTO (ir[13:11]=3'b101): pc <= ir[10:0]; flush.
  - CALL (ir[13:11]=3'b100): push pc (= CALL address+1); pc <= ir[10:0]; flush.
  - RETURN (14'h0008), RETFIE (14'h0009), RETLW (ir[13:10]=4'b1101): pc <= top of stack; pop; flush. The RETLW instruction itself stays valid so execute can load W.
  - pc_load_i=1: pc <= pc_load_addr_i; flush.
  - skip_i=1: pc <= pc+1; flush (discards the instruction fetched this cycle).
- Flush: IR still loads, but ir_valid_o <= 0 and ir_o <= 0 next cycle. One bubble per taken branch.
- Priority when several actions coincide: opcode control-flow > pc_load_i > skip_i. Lower-priority requests are dropped.
- Bubble cycle (ir_valid_o=0): no decode actions; skip_i and pc_load_i are ignored.
- Stack is circular.
  - Push at full overwrites the oldest entry; pointer wraps.
  - Pop at empty returns the entry at the wrapped pointer.
  - stack_depth_o saturates at 0 and STACK_DEPTH.
- Reset mid-branch: all in-flight state is discarded; fetch restarts at RESET_VEC.

Optional Feature:
- Macro: PC_FETCH_STACK_ERR_EN.
- When defined:
  - Adds outputs stack_ovf_o and stack_unf_o.
  - Sticky flags, set on push at full or pop at empty.
  - Cleared only by rst_n.
  - A simulation assertion fires on set.
- When undefined: ports absent; wrap behaviour unchanged.

Decomposition:
- Shared package mcu_pkg holds:
  - localparams PC_W, INSTR_W.
  - Opcode constants OP_GOTO_HI=3'b101, OP_CALL_HI=3'b100, OP_RETLW_HI=4'b1101, INSTR_RETURN=14'h0008, INSTR_RETFIE=14'h0009, INSTR_NOP=14'h0000.
  - Enum fetch_act_e {ACT_SEQ, ACT_JUMP, ACT_CALL, ACT_RET, ACT_SKIP}.
- One sub-module: hw_return_stack. It holds the circular LIFO, push/pop, depth counter and optional error flags.

Test Plan:
1. Reset release with ROM[0..2] = 01A5, 0103, 3001 -> rom_addr_o 0, 1, 2, 3. ir_o 01A5 valid at cycle 2, 0103 at cycle 3. ir_pc_o tracks.
2. GOTO 14'h2804 at 0x12 -> one bubble (ir_valid_o=0), then ir_pc_o=0x004. No stack change.
3. CALL 14'h2030 at 0x05, then RETLW 14'h3400 at 0x30:
   - After the CALL: stack_depth_o=1; bubble; execution at 0x30.
   - RETLW is presented valid; then bubble; then ir_pc_o=0x006; stack_depth_o=0.
4. skip_i=1 on the instruction at 0x0B -> instruction at 0x0C is suppressed (bubble); next valid ir_pc_o=0x0D.
5. stall_i held 3 cycles mid-stream with skip_i=1 and pc_load_i=1 -> pc, ir_o, stack frozen; requests ignored. Resumes unchanged.
6. Nine nested CALLs then nine RETURNs:
   - stack_depth_o saturates at 8.
   - The ninth return reuses the wrapped entry.
   - With PC_FETCH_STACK_ERR_EN, stack_ovf_o=1 after the ninth CALL and stack_unf_o=1 after the ninth RETURN.
